// File: rtl/mem_arb.sv
// mem_arb: two-master arbiter in front of a single-port RAM with 1-cycle synchronous read.
// Masters m0 (core ex stage) and m1 (loader/debug) share the RAM; ties alternate.
// Each transaction walks IDLE -> ACC -> RESP: the request is registered onto ram_* in IDLE,
// the RAM is accessed in ACC, and rdata/ack are returned to the winner in RESP.
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   mX_req/we/addr/wdata/be request from master X (held stable until ack)
//   mX_rdata, mX_ack        read data and one-cycle completion pulse to master X
//   ram_we_o/addr_o/wdata_o/be_o  registered RAM command
//   ram_rdata_i             RAM read data (valid the cycle after ACC)
//   hold_flag_o             pipeline hold request while m0 waits for its ack
module mem_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_be_o,
  input  logic [31:0] ram_rdata_i,
  output logic [2:0]  hold_flag_o
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned HOLD_W = 3;

  localparam logic [HOLD_W-1:0] HOLD_NONE = 3'b000;
  localparam logic [HOLD_W-1:0] HOLD_ID   = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  // Last winner (1 = m1); also serves as the grant of the transaction in flight.
  logic              r_last_gnt;
  logic              w_last_gnt_nxt;
  logic              r_ram_we;
  logic              w_ram_we_nxt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] w_ram_addr_nxt;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] w_ram_wdata_nxt;
  logic [BE_W-1:0]   r_ram_be;
  logic [BE_W-1:0]   w_ram_be_nxt;
  logic              w_win_m1;
  logic              w_resp;

  // m1 wins when alone, or on a tie when m0 was granted last.
  assign w_win_m1 = m1_req & (~m0_req | ~r_last_gnt);

  // State and registered RAM command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_last_gnt  <= 1'b1;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_be    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_gnt  <= w_last_gnt_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_ram_be    <= w_ram_be_nxt;
    end
  end

  // Next-state and next RAM command; we is only set for the ACC cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_gnt_nxt  = r_last_gnt;
    w_ram_we_nxt    = 1'b0;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_ram_be_nxt    = r_ram_be;
    case (r_state)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          w_last_gnt_nxt  = w_win_m1;
          w_ram_we_nxt    = w_win_m1 ? m1_we    : m0_we;
          w_ram_addr_nxt  = w_win_m1 ? m1_addr  : m0_addr;
          w_ram_wdata_nxt = w_win_m1 ? m1_wdata : m0_wdata;
          w_ram_be_nxt    = w_win_m1 ? m1_be    : m0_be;
          w_state_nxt     = S_ACC;
        end
      end
      S_ACC:   w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Response is suppressed while reset is asserted so an abandoned transaction never acks.
  assign w_resp   = (r_state == S_RESP) & rst;
  assign m0_ack   = w_resp & ~r_last_gnt;
  assign m1_ack   = w_resp & r_last_gnt;
  assign m0_rdata = m0_ack ? ram_rdata_i : '0;
  assign m1_rdata = m1_ack ? ram_rdata_i : '0;

  assign hold_flag_o = (m0_req & ~m0_ack) ? HOLD_ID : HOLD_NONE;

  assign ram_we_o    = r_ram_we;
  assign ram_addr_o  = r_ram_addr;
  assign ram_wdata_o = r_ram_wdata;
  assign ram_be_o    = r_ram_be;

endmodule
